// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL reset / clock-enable sequencer.
//   pll_state_t  : sequencer state (WAIT_LOCK, SETTLE, HOLD, RUN)
//   DEF_*        : default parameter values used by pll_reset_ce_gen
//   max_int      : helper for sizing the shared sequencer counter
package pll_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        SETTLE,
        HOLD,
        RUN
    } pll_state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_LOCK_STABLE = 1024;
    localparam int DEF_RESET_HOLD  = 16;

    // 85.909 MHz / 4, /12, /24 -> 21.477, 7.159, 3.580 MHz
    localparam int DEF_DIV_A = 4;
    localparam int DEF_DIV_B = 12;
    localparam int DEF_DIV_C = 24;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_reset_ce_gen_ce_divider.sv
// ce_divider: free-running divide-by-DIV clock-enable generator.
//   clk_sys : system clock
//   reset   : async active-high reset
//   run     : count enable; low clears the phase and forces ce low
//   ce      : registered one-cycle pulse, high the cycle after cnt == DIV-1
module ce_divider #(
    parameter int DIV = 4
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic run,
    output logic ce
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q;
    logic         wrap;

    assign wrap = (cnt_q == W'(DIV - 1));

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            ce    <= 1'b0;
        end else if (!run) begin
            // Clearing here restarts the phase so every RUN entry is aligned.
            cnt_q <= '0;
            ce    <= 1'b0;
        end else begin
            cnt_q <= wrap ? '0 : cnt_q + 1'b1;
            ce    <= wrap;
        end
    end

endmodule

// File: rtl/pll_reset_ce_gen.sv
// pll_reset_ce_gen: qualifies the PLL lock, sequences core reset release and
// produces phase-aligned clock enables for the console core.
//   clk_sys       in  : system clock (PLL outclk_0)
//   reset         in  : async active-high reset
//   pll_locked    in  : PLL lock, asynchronous to clk_sys
//   soft_reset    in  : host/OSD reset request, synchronous level
//   core_reset    out : registered core reset, low only in RUN
//   ce_a/b/c      out : one-cycle enables every DIV_A/B/C cycles in RUN
//   running       out : high while in RUN
//   lock_lost_cnt out : saturating count of lock losses from HOLD or RUN
// DIV_B must be a multiple of DIV_A and DIV_C a multiple of DIV_B so that
// all three enables coincide every DIV_C cycles.
module pll_reset_ce_gen
    import pll_seq_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LOCK_STABLE = DEF_LOCK_STABLE,
    parameter int RESET_HOLD  = DEF_RESET_HOLD,
    parameter int DIV_A       = DEF_DIV_A,
    parameter int DIV_B       = DEF_DIV_B,
    parameter int DIV_C       = DEF_DIV_C
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       soft_reset,
    output logic       core_reset,
    output logic       ce_a,
    output logic       ce_b,
    output logic       ce_c,
    output logic       running,
    output logic [7:0] lock_lost_cnt
);

    localparam int CNT_W = $clog2(max_int(LOCK_STABLE, RESET_HOLD)) + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    pll_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic                   core_reset_d;
    logic                   lost_evt;
    logic                   div_run;

    // Lock synchroniser; locked_s is the only lock view the FSM uses.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    // State register and shared counter.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q || (state_q == HOLD && soft_reset))
                cnt_q <= '0;
            else if (state_q == SETTLE || state_q == HOLD)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // Next state; lock loss is tested first so it wins over soft_reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_LOCK: if (locked_s) state_d = SETTLE;
            SETTLE: begin
                if (!locked_s)                              state_d = WAIT_LOCK;
                else if (cnt_q == CNT_W'(LOCK_STABLE - 1))  state_d = HOLD;
            end
            HOLD: begin
                // soft_reset pins cnt at 0, so it must also block exit when RESET_HOLD==1.
                if (!locked_s)                                           state_d = WAIT_LOCK;
                else if (!soft_reset && cnt_q == CNT_W'(RESET_HOLD - 1)) state_d = RUN;
            end
            RUN: begin
                if (!locked_s)       state_d = WAIT_LOCK;
                else if (soft_reset) state_d = HOLD;
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    // Output decode from current/next state.
    always_comb begin
        core_reset_d = (state_d != RUN);
        lost_evt     = !locked_s && (state_q == HOLD || state_q == RUN);
        // Dividers only count while RUN persists, so the exit cycle emits no pulse.
        div_run      = (state_q == RUN) && (state_d == RUN);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            core_reset    <= 1'b1;
            running       <= 1'b0;
            lock_lost_cnt <= '0;
        end else begin
            core_reset <= core_reset_d;
            running    <= !core_reset_d;
            if (lost_evt && lock_lost_cnt != 8'hFF)
                lock_lost_cnt <= lock_lost_cnt + 8'd1;
        end
    end

    ce_divider #(.DIV(DIV_A)) u_ce_a (
        .clk_sys (clk_sys),
        .reset   (reset),
        .run     (div_run),
        .ce      (ce_a)
    );

    ce_divider #(.DIV(DIV_B)) u_ce_b (
        .clk_sys (clk_sys),
        .reset   (reset),
        .run     (div_run),
        .ce      (ce_b)
    );

    ce_divider #(.DIV(DIV_C)) u_ce_c (
        .clk_sys (clk_sys),
        .reset   (reset),
        .run     (div_run),
        .ce      (ce_c)
    );

endmodule

// File: tb/tb_pll_reset_ce_gen.sv
// Bench for pll_reset_ce_gen with SYNC_STAGES=2, LOCK_STABLE=8, RESET_HOLD=4
// and default divisors. A timing-rule model (lock streak / quiet-cycle counts)
// is compared on every falling edge; directed literals pin the model.
module tb_pll_reset_ce_gen;

    localparam int SS = 2;
    localparam int LS = 8;
    localparam int RH = 4;
    localparam int DA = 4;
    localparam int DB = 12;
    localparam int DC = 24;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic       soft_reset;
    logic       core_reset;
    logic       ce_a, ce_b, ce_c;
    logic       running;
    logic [7:0] lock_lost_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pll_reset_ce_gen #(
        .SYNC_STAGES (SS),
        .LOCK_STABLE (LS),
        .RESET_HOLD  (RH),
        .DIV_A       (DA),
        .DIV_B       (DB),
        .DIV_C       (DC)
    ) dut (
        .clk_sys       (clk),
        .reset         (reset),
        .pll_locked    (pll_locked),
        .soft_reset    (soft_reset),
        .core_reset    (core_reset),
        .ce_a          (ce_a),
        .ce_b          (ce_b),
        .ce_c          (ce_c),
        .running       (running),
        .lock_lost_cnt (lock_lost_cnt)
    );

    // Model: lock is seen SS edges late; HOLD is reached after LS+1 consecutive
    // locked edges; RUN needs RH soft_reset-free edges beyond that point.
    // Enables fire every DIV edges measured from the RUN entry edge.
    logic [SS-1:0] m_lk;
    int m_streak, m_quiet, m_runlen, m_lost;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_lk     <= '0;
            m_streak <= 0;
            m_quiet  <= 0;
            m_runlen <= 0;
            m_lost   <= 0;
        end else begin : upd
            int s, q, l, r;
            s = m_streak;
            q = m_quiet;
            l = m_lost;
            if (!m_lk[SS-1]) begin
                if (s >= LS + 1 && l < 255) l = l + 1;
                s = 0;
                q = 0;
            end else begin
                s = s + 1;
                if (s > LS + 1) q = soft_reset ? 0 : q + 1;
            end
            r = (q >= RH) ? m_runlen + 1 : 0;
            m_lk     <= {m_lk[SS-2:0], pll_locked};
            m_streak <= s;
            m_quiet  <= q;
            m_lost   <= l;
            m_runlen <= r;
        end
    end

    function automatic int exp_ce(input int runlen, input int div);
        return (runlen > 1 && (runlen - 1) % div == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_running",    int'(running),       (m_quiet >= RH) ? 1 : 0);
        chk("m_core_reset", int'(core_reset),    (m_quiet >= RH) ? 0 : 1);
        chk("m_ce_a",       int'(ce_a),          exp_ce(m_runlen, DA));
        chk("m_ce_b",       int'(ce_b),          exp_ce(m_runlen, DB));
        chk("m_ce_c",       int'(ce_c),          exp_ce(m_runlen, DC));
        chk("m_lost",       int'(lock_lost_cnt), m_lost);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_core_reset"}, int'(core_reset), 1);
        chk({nm, "_running"},    int'(running), 0);
        chk({nm, "_ce"},         int'({ce_a, ce_b, ce_c}), 0);
        chk({nm, "_lost"},       int'(lock_lost_cnt), 0);
    endtask

    int lost_before;

    initial begin
        reset      = 1'b1;
        pll_locked = 1'b0;
        soft_reset = 1'b0;
        #3;
        chk_reset_vals("por");
        step(2);
        reset = 1'b0;
        step(1);

        // Glitch during SETTLE: streak restarts, RUN at edge 21, no loss counted.
        pll_locked = 1'b1;
        step(5);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(14);
        chk("glitch_run_e20", int'(running), 0);
        step(1);
        chk("glitch_run_e21", int'(running), 1);
        chk("glitch_lost", int'(lock_lost_cnt), 0);

        // Fresh start: lock already high when reset releases at edge 0.
        reset = 1'b1;
        #1;
        chk_reset_vals("rst1");
        step(1);
        reset = 1'b0;
        step(14);
        chk("t1_run_e14", int'(running), 0);
        chk("t1_crst_e14", int'(core_reset), 1);
        step(1);
        chk("t1_run_e15", int'(running), 1);
        chk("t1_crst_e15", int'(core_reset), 0);
        step(3);
        chk("t1_cea_e18", int'(ce_a), 0);
        step(1);
        chk("t1_cea_e19", int'(ce_a), 1);
        chk("t1_ceb_e19", int'(ce_b), 0);
        step(8);
        chk("t1_ceb_e27", int'(ce_b), 1);
        chk("t1_cec_e27", int'(ce_c), 0);
        step(12);
        chk("t1_all_e39", int'({ce_a, ce_b, ce_c}), 7);
        step(24);
        chk("t1_all_e63", int'({ce_a, ce_b, ce_c}), 7);

        // Lock loss in RUN: reset re-asserts on the third edge.
        pll_locked = 1'b0;
        step(2);
        chk("t3_run_l2", int'(running), 1);
        step(1);
        chk("t3_crst_l3", int'(core_reset), 1);
        chk("t3_ce_l3", int'({ce_a, ce_b, ce_c}), 0);
        chk("t3_lost", int'(lock_lost_cnt), 1);
        step(2);
        pll_locked = 1'b1;
        step(14);
        chk("t3_relock_e14", int'(running), 0);
        step(1);
        chk("t3_relock_e15", int'(running), 1);

        // soft_reset for 10 cycles in RUN.
        step(5);
        soft_reset = 1'b1;
        step(1);
        chk("t4_hold_crst", int'(core_reset), 1);
        step(9);
        soft_reset = 1'b0;
        step(3);
        chk("t4_run_f3", int'(running), 0);
        step(1);
        chk("t4_run_f4", int'(running), 1);
        step(3);
        chk("t4_cea_r3", int'(ce_a), 0);
        step(1);
        chk("t4_cea_r4", int'(ce_a), 1);

        // soft_reset and lock loss seen in the same RUN cycle.
        step(10);
        lost_before = int'(lock_lost_cnt);
        pll_locked = 1'b0;
        step(2);
        soft_reset = 1'b1;
        step(1);
        chk("t5_run", int'(running), 0);
        chk("t5_lost", int'(lock_lost_cnt), lost_before + 1);
        soft_reset = 1'b0;
        step(3);

        // 300 losses from HOLD saturate the counter.
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b1;
            step(11);
            pll_locked = 1'b0;
            step(4);
        end
        chk("t6_sat", int'(lock_lost_cnt), 255);
        pll_locked = 1'b1;
        step(15);
        chk("t6_run", int'(running), 1);
        step(7);
        reset = 1'b1;
        #1;
        chk_reset_vals("t6_async");
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
